// File: rtl/cw_sequencer.sv
// Fetch/execute sequencer: consumes the decoder control word and drives datapath strobes, gated by RAM ready.
// Optional build macro PERF_COUNTERS_EN adds cycle_cnt / retired_cnt outputs.
module cw_sequencer #(
  parameter int unsigned MAX_EXEC   = 4,
  parameter logic [1:0]  FETCH_PCFS = 2'b01
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [32:0] cw_in,
  input  logic [63:0] K_in,
  input  logic [31:0] data_in,
  input  logic [4:0]  status_in,
  input  logic        mem_ready,
  output logic [31:0] I,
  output logic [1:0]  state,
  output logic [4:0]  status,
  output logic        alu_en,
  output logic        alu_bs,
  output logic        rf_b_en,
  output logic        rf_w,
  output logic        ram_en,
  output logic        ram_w,
  output logic        pc_en,
  output logic        pc_is,
  output logic [4:0]  alu_fs,
  output logic [4:0]  rf_sa,
  output logic [4:0]  rf_sb,
  output logic [4:0]  rf_da,
  output logic [1:0]  pc_fs,
  output logic [63:0] K,
  output logic        fetch,
  output logic        fault
`ifdef PERF_COUNTERS_EN
  ,
  output logic [31:0] cycle_cnt,
  output logic [31:0] retired_cnt
`endif
);

  localparam int unsigned CNT_W = $clog2(MAX_EXEC + 1);

  typedef enum logic {PH_FETCH = 1'b0, PH_EXEC = 1'b1} phase_e;

  phase_e           phase_q, phase_d;
  logic [31:0]      ir_q, ir_d;
  logic [1:0]       state_q, state_d;
  logic [4:0]       status_q, status_d;
  logic [CNT_W-1:0] exec_cnt_q, exec_cnt_d;
  logic             fault_q, fault_d;

  logic in_exec;
  logic stall;
  logic commit;
  logic wd_abort;

  // A cycle that touches RAM only commits once the RAM reports ready.
  assign in_exec  = (phase_q == PH_EXEC);
  assign stall    = in_exec && cw_in[8] && !mem_ready;
  assign commit   = in_exec && !stall;
  assign wd_abort = commit && (cw_in[1:0] != 2'b00) &&
                    (exec_cnt_q == CNT_W'(MAX_EXEC - 1));

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      phase_q    <= PH_FETCH;
      ir_q       <= '0;
      state_q    <= '0;
      status_q   <= '0;
      exec_cnt_q <= '0;
      fault_q    <= 1'b0;
    end else begin
      phase_q    <= phase_d;
      ir_q       <= ir_d;
      state_q    <= state_d;
      status_q   <= status_d;
      exec_cnt_q <= exec_cnt_d;
      fault_q    <= fault_d;
    end
  end

  always_comb begin
    phase_d    = phase_q;
    ir_d       = ir_q;
    state_d    = state_q;
    status_d   = status_q;
    exec_cnt_d = exec_cnt_q;
    fault_d    = wd_abort;
    case (phase_q)
      PH_FETCH: begin
        if (mem_ready) begin
          ir_d       = data_in;
          state_d    = 2'b00;
          exec_cnt_d = '0;
          phase_d    = PH_EXEC;
        end
      end
      PH_EXEC: begin
        if (commit) begin
          if (cw_in[2]) status_d = status_in;
          if (cw_in[1:0] == 2'b00 || wd_abort) begin
            phase_d = PH_FETCH;
          end else begin
            state_d    = cw_in[1:0];
            exec_cnt_d = exec_cnt_q + CNT_W'(1);
          end
        end
      end
      default: phase_d = PH_FETCH;
    endcase
  end

  always_comb begin
    alu_en  = 1'b0;
    alu_bs  = 1'b0;
    alu_fs  = 5'd0;
    rf_b_en = 1'b0;
    rf_sa   = 5'd0;
    rf_sb   = 5'd0;
    rf_da   = 5'd0;
    rf_w    = 1'b0;
    ram_en  = 1'b0;
    ram_w   = 1'b0;
    pc_en   = 1'b0;
    pc_fs   = 2'b00;
    pc_is   = 1'b0;
    K       = '0;
    if (!reset) begin
      // Outputs stay quiet for the whole reset window.
    end else if (phase_q == PH_FETCH) begin
      ram_en = 1'b1;
      rf_sa  = 5'd31;
      rf_sb  = 5'd31;
      rf_da  = 5'd31;
      pc_fs  = mem_ready ? FETCH_PCFS : 2'b00;
    end else begin
      alu_en  = cw_in[32];
      alu_bs  = cw_in[31];
      alu_fs  = cw_in[30:26];
      rf_b_en = cw_in[25];
      rf_sa   = cw_in[24:20];
      rf_sb   = cw_in[19:15];
      rf_da   = cw_in[14:10];
      rf_w    = stall ? 1'b0 : cw_in[9];
      ram_en  = cw_in[8];
      ram_w   = cw_in[7];
      pc_en   = stall ? 1'b0 : cw_in[6];
      pc_fs   = stall ? 2'b00 : cw_in[5:4];
      pc_is   = cw_in[3];
      K       = K_in;
    end
  end

  assign I      = ir_q;
  assign state  = state_q;
  assign status = status_q;
  assign fault  = fault_q;
  assign fetch  = (phase_q == PH_FETCH);

`ifdef PERF_COUNTERS_EN
  logic [31:0] cycle_cnt_q, retired_cnt_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cycle_cnt_q   <= '0;
      retired_cnt_q <= '0;
    end else begin
      cycle_cnt_q <= cycle_cnt_q + 32'd1;
      if (commit && phase_d == PH_FETCH) retired_cnt_q <= retired_cnt_q + 32'd1;
    end
  end

  assign cycle_cnt   = cycle_cnt_q;
  assign retired_cnt = retired_cnt_q;
`endif

endmodule

// File: tb/tb_cw_sequencer.sv
// Randomised and directed bench for cw_sequencer: a driver pushes per-cycle expected outputs from a
// rule-level reference model, and a negedge monitor pops and compares them against the DUT.
module tb_cw_sequencer;

  localparam int MAX_EXEC = 4;
  localparam int EW       = 135;

  logic        clock;
  logic        reset;
  logic [32:0] cw_in;
  logic [63:0] K_in;
  logic [31:0] data_in;
  logic [4:0]  status_in;
  logic        mem_ready;
  logic [31:0] I;
  logic [1:0]  state;
  logic [4:0]  status;
  logic        alu_en, alu_bs, rf_b_en, rf_w, ram_en, ram_w, pc_en, pc_is;
  logic [4:0]  alu_fs, rf_sa, rf_sb, rf_da;
  logic [1:0]  pc_fs;
  logic [63:0] K;
  logic        fetch, fault;
`ifdef PERF_COUNTERS_EN
  logic [31:0] cycle_cnt, retired_cnt;
`endif

  cw_sequencer #(.MAX_EXEC(MAX_EXEC), .FETCH_PCFS(2'b01)) dut (
    .clock(clock), .reset(reset), .cw_in(cw_in), .K_in(K_in), .data_in(data_in),
    .status_in(status_in), .mem_ready(mem_ready), .I(I), .state(state), .status(status),
    .alu_en(alu_en), .alu_bs(alu_bs), .rf_b_en(rf_b_en), .rf_w(rf_w), .ram_en(ram_en),
    .ram_w(ram_w), .pc_en(pc_en), .pc_is(pc_is), .alu_fs(alu_fs), .rf_sa(rf_sa),
    .rf_sb(rf_sb), .rf_da(rf_da), .pc_fs(pc_fs), .K(K), .fetch(fetch), .fault(fault)
`ifdef PERF_COUNTERS_EN
    , .cycle_cnt(cycle_cnt), .retired_cnt(retired_cnt)
`endif
  );

  // ---------------- clock / reset ----------------
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // ---------------- scoreboard ----------------
  logic [EW-1:0] exp_q[$];
  string         tag_q[$];
  int            n_checks = 0;
  int            n_errors = 0;

  // ---------------- reference model state ----------------
  bit          m_fetch  = 1'b1;
  logic [31:0] m_ir     = '0;
  logic [1:0]  m_state  = '0;
  logic [4:0]  m_status = '0;
  int          m_commits = 0;   // non-final commits in the current instruction
  bit          m_fault  = 1'b0;

  // One clock of the reference: expected outputs for this cycle, then advance the model.
  task automatic model_cycle(input bit rst_n, input logic [32:0] cw, input logic [63:0] k,
                             input logic [31:0] d, input logic [4:0] st, input bit rdy,
                             output logic [EW-1:0] e);
    logic        ae, ab, be, w, re, rw, pe, pi;
    logic [4:0]  fs, sa, sb, da;
    logic [1:0]  pf;
    logic [63:0] ko;
    bit          ram_wait, finish_instr, abort;
    if (!rst_n) begin
      m_fetch = 1'b1; m_ir = '0; m_state = '0; m_status = '0; m_commits = 0; m_fault = 1'b0;
    end
    {ae, ab, be, w, re, rw, pe, pi} = '0;
    {fs, sa, sb, da} = '0;
    pf = 2'b00;
    ko = '0;
    ram_wait = !m_fetch && cw[8] && !rdy;
    if (rst_n && m_fetch) begin
      re = 1'b1; sa = 5'd31; sb = 5'd31; da = 5'd31;
      pf = rdy ? 2'b01 : 2'b00;
    end else if (rst_n) begin
      ae = cw[32]; ab = cw[31]; fs = cw[30:26]; be = cw[25];
      sa = cw[24:20]; sb = cw[19:15]; da = cw[14:10];
      w  = ram_wait ? 1'b0 : cw[9];
      re = cw[8]; rw = cw[7];
      pe = ram_wait ? 1'b0 : cw[6];
      pf = ram_wait ? 2'b00 : cw[5:4];
      pi = cw[3];
      ko = k;
    end
    e = {m_ir, m_state, m_status, m_fetch, m_fault, ae, ab, fs, be, sa, sb, da,
         w, re, rw, pe, pf, pi, ko};
    if (rst_n) begin
      abort = 1'b0;
      if (m_fetch) begin
        if (rdy) begin
          m_ir = d; m_state = 2'b00; m_commits = 0; m_fetch = 1'b0;
        end
      end else if (!ram_wait) begin
        if (cw[2]) m_status = st;
        finish_instr = (cw[1:0] == 2'b00);
        if (!finish_instr && m_commits + 1 >= MAX_EXEC) abort = 1'b1;
        if (finish_instr || abort) m_fetch = 1'b1;
        else begin
          m_state = cw[1:0];
          m_commits++;
        end
      end
      m_fault = abort;
    end
  endtask

  // ---------------- driver ----------------
  task automatic drive(input string tag, input bit rst_n, input logic [32:0] cw,
                       input logic [31:0] d, input logic [4:0] st, input bit rdy);
    logic [EW-1:0] e;
    logic [63:0]   k;
    k = {$urandom, $urandom};
    reset = rst_n; cw_in = cw; K_in = k; data_in = d; status_in = st; mem_ready = rdy;
    model_cycle(rst_n, cw, k, d, st, rdy, e);
    exp_q.push_back(e);
    tag_q.push_back(tag);
    @(posedge clock);
    #1;
  endtask

  function automatic logic [32:0] mk_cw(input logic alu_e, input logic [4:0] da, input logic rfw,
                                        input logic re, input logic [1:0] pf, input logic sld,
                                        input logic [1:0] nxt);
    logic [32:0] c;
    c = '0;
    c[32] = alu_e; c[14:10] = da; c[9] = rfw; c[8] = re;
    c[5:4] = pf; c[2] = sld; c[1:0] = nxt;
    return c;
  endfunction

  function automatic logic [32:0] rand_cw();
    logic [32:0] c;
    c = {$urandom, $urandom};
    c[8] = ($urandom_range(0, 2) == 0);
    c[1:0] = ($urandom_range(0, 2) == 0) ? 2'b00 : 2'(($urandom_range(1, 3)));
    return c;
  endfunction

  // ---------------- monitor ----------------
  always @(negedge clock) begin
    logic [EW-1:0] act, e;
    string t;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      act = {I, state, status, fetch, fault, alu_en, alu_bs, alu_fs, rf_b_en, rf_sa, rf_sb,
             rf_da, rf_w, ram_en, ram_w, pc_en, pc_fs, pc_is, K};
      n_checks++;
      if (act !== e) begin
        n_errors++;
        $display("FAIL %s @%0t: got %h expected %h", t, $time, act, e);
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [32:0] bl_cw;
    reset = 1'b0; cw_in = '0; K_in = '0; data_in = '0; status_in = '0; mem_ready = 1'b0;
    @(posedge clock);
    #1;

    for (int i = 0; i < 4; i++)
      drive("reset_hold", 1'b0, rand_cw(), $urandom, 5'($urandom), 1'($urandom));

    // Release with ready: the BL word loads straight away.
    drive("reset_release_fetch", 1'b1, rand_cw(), 32'h9400_0010, 5'd0, 1'b1);
    bl_cw = mk_cw(1'b0, 5'd30, 1'b1, 1'b0, 2'b11, 1'b0, 2'b00);
    drive("bl_exec", 1'b1, bl_cw, $urandom, 5'd0, 1'($urandom));

    for (int i = 0; i < 3; i++)
      drive("fetch_stall", 1'b1, rand_cw(), $urandom, 5'd0, 1'b0);
    drive("fetch_ready", 1'b1, rand_cw(), $urandom, 5'd0, 1'b1);

    // Multi-cycle 00 -> 01 -> 10 -> 00 with a two-cycle RAM stall and a status load.
    drive("mc_s0", 1'b1, mk_cw(1'b1, 5'd3, 1'b1, 1'b0, 2'b00, 1'b0, 2'b01), $urandom, 5'd0, 1'b0);
    for (int i = 0; i < 2; i++)
      drive("mc_stall", 1'b1, mk_cw(1'b1, 5'd4, 1'b1, 1'b1, 2'b01, 1'b1, 2'b10),
            $urandom, 5'b10101, 1'b0);
    drive("mc_s1_commit", 1'b1, mk_cw(1'b1, 5'd4, 1'b1, 1'b1, 2'b01, 1'b1, 2'b10),
          $urandom, 5'b10101, 1'b1);
    drive("mc_s2", 1'b1, mk_cw(1'b0, 5'd5, 1'b0, 1'b0, 2'b00, 1'b0, 2'b00), $urandom, 5'd0, 1'b0);
    drive("mc_fetch", 1'b1, rand_cw(), $urandom, 5'd0, 1'b1);

    // Watchdog: next_state stuck at 01.
    for (int i = 0; i < MAX_EXEC; i++)
      drive("wd_exec", 1'b1, mk_cw(1'b1, 5'd7, 1'b1, 1'b0, 2'b00, 1'b0, 2'b01), $urandom, 5'd0, 1'b1);
    drive("wd_fetch", 1'b1, rand_cw(), $urandom, 5'd0, 1'b0);
    drive("wd_after", 1'b1, rand_cw(), $urandom, 5'd0, 1'b1);

    for (int i = 0; i < 600; i++)
      drive("random", ($urandom_range(0, 60) != 0), rand_cw(), $urandom, 5'($urandom),
            ($urandom_range(0, 3) != 0));

    for (int i = 0; i < 5 && exp_q.size() > 0; i++) @(negedge clock);
    #1;
    if (exp_q.size() != 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
